// File: rtl/wb_intctrl.sv
// wb_intctrl: Wishbone (pipelined) slave interrupt controller.
// Registers: ENABLE (0x00), PENDING (0x04, W1C), STATUS (0x08), and
// VECTOR[i] (0x40 + 4*i). The lowest pending-and-enabled source is
// presented to the CPU core together with its latched handler address.
// Build option: define WB_INTCTRL_EDGE_EN for rising-edge latched sources.
// When it is undefined, PENDING mirrors the registered irq_src (level mode).
module wb_intctrl #(
   parameter int pc_bit_size = 25,
   parameter int num_irq     = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wb_cyc_s,
   input  logic                   wb_stb_s,
   input  logic                   wb_we_s,
   input  logic [31:0]            wb_adr_s,
   input  logic [31:0]            wb_dat_i_s,
   input  logic [3:0]             wb_sel_s,
   output logic [31:0]            wb_dat_o_s,
   output logic                   wb_ack_s,
   output logic                   wb_stall_s,
   input  logic [num_irq-1:0]     irq_src,
   output logic                   cpu_irq,
   output logic [pc_bit_size-1:0] interuptadr,
   input  logic                   interrutack,
   input  logic                   exitint
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam logic [4:0] A_ENABLE  = 5'd0;
   localparam logic [4:0] A_PENDING = 5'd1;
   localparam logic [4:0] A_STATUS  = 5'd2;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [3:0]             r_id;
   logic                   r_cpu_irq;
   logic [pc_bit_size-1:0] r_intadr;
   logic [num_irq-1:0]     r_enable;
   logic [num_irq-1:0]     r_src_q;
   logic [num_irq-1:0]     w_pending;
   logic [pc_bit_size-1:0] r_vector [num_irq];
   logic                   r_ack;
   logic [31:0]            r_dat_o;

   logic                   w_accept;
   logic                   w_wr;
   logic                   w_rd;
   logic [4:0]             w_widx;
   logic [31:0]            w_bmask;
   logic [31:0]            w_rdata;
   logic [num_irq-1:0]     w_req;
   logic                   w_any;
   logic [3:0]             w_low_id;
   logic [pc_bit_size-1:0] w_low_vec;
   logic                   w_take;
   logic                   w_ack_clr;
   logic                   w_unused;

   assign w_accept   = wb_cyc_s & wb_stb_s;
   assign w_wr       = w_accept & wb_we_s;
   assign w_rd       = w_accept & ~wb_we_s;
   assign w_widx     = wb_adr_s[6:2];
   assign wb_stall_s = 1'b0;
   assign wb_ack_s   = r_ack;
   assign wb_dat_o_s = r_dat_o;
   assign cpu_irq    = r_cpu_irq;
   assign interuptadr = r_intadr;

   // Address bits outside the decoded window and data bits above register widths are don't-care.
   assign w_unused = ^{wb_adr_s[31:7], wb_adr_s[1:0], wb_dat_i_s, w_bmask, w_ack_clr};

   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_bmask
      assign w_bmask[8*gi +: 8] = {8{wb_sel_s[gi]}};
   end

`ifdef WB_INTCTRL_EDGE_EN
   logic [num_irq-1:0] r_src_d;
   logic [num_irq-1:0] r_pending;
   logic [num_irq-1:0] w_rise;
   logic [num_irq-1:0] w_clr;

   assign w_rise    = r_src_q & ~r_src_d;
   assign w_pending = r_pending;

   // Clear mask: W1C write bits plus the acknowledged source.
   always_comb begin
      w_clr = '0;
      if (w_wr && (w_widx == A_PENDING))
         w_clr = wb_dat_i_s[num_irq-1:0] & w_bmask[num_irq-1:0];
      if (w_ack_clr) begin
         for (int i = 0; i < num_irq; i++)
            if (r_id == 4'(i)) w_clr[i] = 1'b1;
      end
   end

   // Source history and sticky pending bits; a new edge wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_src_q   <= '0;
         r_src_d   <= '0;
         r_pending <= '0;
      end else begin
         r_src_q   <= irq_src;
         r_src_d   <= r_src_q;
         r_pending <= (r_pending & ~w_clr) | w_rise;
      end
   end
`else
   assign w_pending = r_src_q;

   // Level mode: pending is simply the registered source lines.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_src_q <= '0;
      else      r_src_q <= irq_src;
   end
`endif

   assign w_req = w_pending & r_enable;

   // Priority pick: lowest requesting index and its vector.
   always_comb begin
      w_any     = 1'b0;
      w_low_id  = '0;
      w_low_vec = '0;
      for (int i = num_irq - 1; i >= 0; i--) begin
         if (w_req[i]) begin
            w_any    = 1'b1;
            w_low_id = 4'(i);
         end
      end
      for (int i = 0; i < num_irq; i++)
         if (w_low_id == 4'(i)) w_low_vec = r_vector[i];
   end

   // FSM next state: arbitrate in IDLE, wait for CPU acceptance, then for return.
   always_comb begin
      w_state_next = r_state;
      w_take       = 1'b0;
      w_ack_clr    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_next = ST_REQ;
               w_take       = 1'b1;
            end
         end
         ST_REQ: begin
            if (interrutack) begin
               w_state_next = ST_ACTIVE;
               w_ack_clr    = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (exitint) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // FSM state, registered cpu_irq, and the latched id/handler address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cpu_irq <= 1'b0;
         r_id      <= '0;
         r_intadr  <= '0;
      end else begin
         r_state   <= w_state_next;
         r_cpu_irq <= (w_state_next == ST_REQ);
         if (w_take) begin
            r_id     <= w_low_id;
            r_intadr <= w_low_vec;
         end
      end
   end

   // ENABLE register with byte-select writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_enable <= '0;
      else if (w_wr && (w_widx == A_ENABLE))
         r_enable <= (r_enable & ~w_bmask[num_irq-1:0])
                   | (wb_dat_i_s[num_irq-1:0] & w_bmask[num_irq-1:0]);
   end

   // VECTOR registers with byte-select writes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < num_irq; i++) r_vector[i] <= '0;
      end else if (w_wr) begin
         for (int i = 0; i < num_irq; i++)
            if (w_widx == 5'(16 + i))
               r_vector[i] <= (r_vector[i] & ~w_bmask[pc_bit_size-1:0])
                            | (wb_dat_i_s[pc_bit_size-1:0] & w_bmask[pc_bit_size-1:0]);
      end
   end

   // Read mux; unmapped addresses return zero.
   always_comb begin
      w_rdata = '0;
      case (w_widx)
         A_ENABLE:  w_rdata = 32'(r_enable);
         A_PENDING: w_rdata = 32'(w_pending);
         A_STATUS:  w_rdata = {26'b0, r_state, r_id};
         default: begin
            for (int i = 0; i < num_irq; i++)
               if (w_widx == 5'(16 + i)) w_rdata = 32'(r_vector[i]);
         end
      endcase
   end

   // Bus response: one ack per accepted request, data only on read acks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ack   <= 1'b0;
         r_dat_o <= '0;
      end else begin
         r_ack   <= w_accept;
         r_dat_o <= w_rd ? w_rdata : 32'd0;
      end
   end

endmodule

// File: tb/tb_wb_intctrl.sv
// tb_wb_intctrl: self-checking bench for wb_intctrl (num_irq=8, pc_bit_size=25).
// Table-driven register vectors, hand-written interrupt sequences, and
// randomized pipelined bus traffic against a register-file model.
module tb_wb_intctrl;

   localparam int NUM = 8;
   localparam int PC  = 25;
`ifdef WB_INTCTRL_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            wb_cyc_s = 1'b0, wb_stb_s = 1'b0, wb_we_s = 1'b0;
   logic [31:0]     wb_adr_s = '0, wb_dat_i_s = '0;
   logic [3:0]      wb_sel_s = '0;
   logic [31:0]     wb_dat_o_s;
   logic            wb_ack_s, wb_stall_s;
   logic [NUM-1:0]  irq_src = '0;
   logic            cpu_irq;
   logic [PC-1:0]   interuptadr;
   logic            interrutack = 1'b0, exitint = 1'b0;

   int checks = 0;
   int errors = 0;

   wb_intctrl #(.pc_bit_size(PC), .num_irq(NUM)) dut (
      .clk(clk), .rst(rst),
      .wb_cyc_s(wb_cyc_s), .wb_stb_s(wb_stb_s), .wb_we_s(wb_we_s),
      .wb_adr_s(wb_adr_s), .wb_dat_i_s(wb_dat_i_s), .wb_sel_s(wb_sel_s),
      .wb_dat_o_s(wb_dat_o_s), .wb_ack_s(wb_ack_s), .wb_stall_s(wb_stall_s),
      .irq_src(irq_src), .cpu_irq(cpu_irq), .interuptadr(interuptadr),
      .interrutack(interrutack), .exitint(exitint)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single bus transaction; returns read data captured with the ack.
   task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
      wb_cyc_s = 1'b1; wb_stb_s = 1'b1; wb_we_s = we;
      wb_adr_s = adr; wb_dat_i_s = dat; wb_sel_s = sel;
      step();
      wb_cyc_s = 1'b0; wb_stb_s = 1'b0; wb_we_s = 1'b0;
      check("bus_ack", 32'(wb_ack_s), 32'd1);
      rd = wb_dat_o_s;
      $display("txn we=%0b adr=%h dat=%h sel=%h rd=%h", we, adr, dat, sel, rd);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] rd;
      bus(1'b1, adr, dat, 4'hF, rd);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] rd;
      bus(1'b0, adr, 32'd0, 4'hF, rd);
      check(name, rd, exp);
   endtask

   // Wait (bounded) for cpu_irq; drop_mask sources are released after the first edge.
   task automatic wait_irq(input logic [NUM-1:0] drop_mask, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
         if (cnt == 1) irq_src = irq_src & ~drop_mask;
      end while (!cpu_irq && cnt < 20);
      check("irq_timeout", 32'(cpu_irq), 32'd1);
   endtask

   task automatic pulse_ack();
      interrutack = 1'b1; step(); interrutack = 1'b0;
   endtask

   task automatic pulse_exit();
      exitint = 1'b1; step(); exitint = 1'b0;
   endtask

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   // Register-file model for random traffic: bits each address can hold.
   function automatic logic [31:0] hold_mask(input int idx);
      if (idx == 0) return 32'((64'd1 << NUM) - 1);
      if (idx >= 16 && idx < 16 + NUM) return 32'((64'd1 << PC) - 1);
      return 32'd0;
   endfunction

   initial begin
      vec_t        tbl [17];
      logic [31:0] rd;
      int          cnt;
      logic [31:0] model [32];
      logic [31:0] b2b_adr [3];
      logic [31:0] b2b_exp [3];

      tbl[0]  = '{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, 32'h0};
      tbl[1]  = '{1'b0, 32'h00, 32'h0,         4'hF, 32'h0000_00FF};
      tbl[2]  = '{1'b1, 32'h00, 32'h0,         4'h0, 32'h0};
      tbl[3]  = '{1'b0, 32'h00, 32'h0,         4'hF, 32'h0000_00FF};
      tbl[4]  = '{1'b1, 32'h00, 32'h0,         4'h1, 32'h0};
      tbl[5]  = '{1'b0, 32'h00, 32'h0,         4'hF, 32'h0};
      tbl[6]  = '{1'b1, 32'h4C, 32'hDEAD_BEEF, 4'hF, 32'h0};
      tbl[7]  = '{1'b0, 32'h4C, 32'h0,         4'hF, 32'h00AD_BEEF};
      tbl[8]  = '{1'b1, 32'h4C, 32'h1122_3344, 4'h2, 32'h0};
      tbl[9]  = '{1'b0, 32'h4C, 32'h0,         4'hF, 32'h00AD_33EF};
      tbl[10] = '{1'b1, 32'h7C, 32'hFFFF_FFFF, 4'hF, 32'h0};
      tbl[11] = '{1'b0, 32'h7C, 32'h0,         4'hF, 32'h0};
      tbl[12] = '{1'b0, 32'h08, 32'h0,         4'hF, 32'h0};
      tbl[13] = '{1'b1, 32'h08, 32'hFF,        4'hF, 32'h0};
      tbl[14] = '{1'b0, 32'h08, 32'h0,         4'hF, 32'h0};
      tbl[15] = '{1'b0, 32'h8000_0004, 32'h0,  4'hF, 32'h0};
      tbl[16] = '{1'b1, 32'h4C, 32'h0,         4'hF, 32'h0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ack",   32'(wb_ack_s),    32'd0);
      check("rst_dat",   wb_dat_o_s,       32'd0);
      check("rst_irq",   32'(cpu_irq),     32'd0);
      check("rst_adr",   32'(interuptadr), 32'd0);
      check("rst_stall", 32'(wb_stall_s),  32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Table-driven register access
      for (int i = 0; i < 17; i++) begin
         bus(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rd);
         check($sformatf("tbl%0d", i), rd, tbl[i].exp);
      end

      // Basic request: vector 2, enable bit 2, one-cycle source pulse
      wr(32'h48, 32'h0001000);
      wr(32'h00, 32'h04);
      irq_src[2] = 1'b1;
      wait_irq(8'h04, cnt);
      check("irq_latency", 32'(cnt), EDGE ? 32'd3 : 32'd2);
      check("req_adr", 32'(interuptadr), 32'h0001000);
      rd_chk("req_status", 32'h08, 32'h12);
      pulse_exit();
      rd_chk("req_exit_ignored", 32'h08, 32'h12);
      wr(32'h48, 32'h0000ABC);
      check("req_adr_hold", 32'(interuptadr), 32'h0001000);
      check("req_irq_hold", 32'(cpu_irq), 32'd1);

      // Acceptance and return
      pulse_ack();
      check("ack_irq_drop", 32'(cpu_irq), 32'd0);
      rd_chk("active_status", 32'h08, 32'h22);
      rd_chk("active_pending", 32'h04, 32'h0);
      irq_src[4] = 1'b1;
      repeat (3) step();
      wr(32'h04, 32'h10);
      rd_chk("w1c_pending", 32'h04, EDGE ? 32'h0 : 32'h10);
      irq_src[4] = 1'b0;
      repeat (2) step();
      pulse_exit();
      bus(1'b0, 32'h08, 32'h0, 4'hF, rd);
      check("exit_state", rd & 32'h30, 32'h0);

      // Priority: sources 1 and 5 together
      wr(32'h44, 32'h111);
      wr(32'h54, 32'h555);
      wr(32'h00, 32'h22);
      irq_src[1] = 1'b1;
      irq_src[5] = 1'b1;
      wait_irq(8'h00, cnt);
      check("prio_adr1", 32'(interuptadr), 32'h111);
      rd_chk("prio_status1", 32'h08, 32'h11);
      interrutack = 1'b1;
      exitint = 1'b1;
      step();
      interrutack = 1'b0;
      exitint = 1'b0;
      rd_chk("ack_exit_same", 32'h08, 32'h21);
      irq_src[1] = 1'b0;
      repeat (2) step();
      pulse_exit();
      wait_irq(8'h00, cnt);
      check("prio_adr5", 32'(interuptadr), 32'h555);
      rd_chk("prio_status5", 32'h08, 32'h15);
      pulse_ack();
      irq_src[5] = 1'b0;
      repeat (2) step();
      pulse_exit();
      repeat (3) step();
      check("no_rearb", 32'(cpu_irq), 32'd0);

      // Back-to-back reads
      wr(32'h00, 32'h5A);
      b2b_adr = '{32'h00, 32'h04, 32'h08};
      b2b_exp = '{32'h5A, 32'h00, 32'h05};
      wb_cyc_s = 1'b1; wb_stb_s = 1'b1; wb_we_s = 1'b0; wb_sel_s = 4'hF;
      for (int i = 0; i < 3; i++) begin
         wb_adr_s = b2b_adr[i];
         step();
         checks++;
         if (wb_ack_s !== 1'b1 || wb_stall_s !== 1'b0 || wb_dat_o_s !== b2b_exp[i]) begin
            errors++;
            $display("FAIL b2b%0d ack=%b stall=%b act=%h exp=%h",
                     i, wb_ack_s, wb_stall_s, wb_dat_o_s, b2b_exp[i]);
         end
         $display("txn b2b adr=%h rd=%h", b2b_adr[i], wb_dat_o_s);
      end
      wb_cyc_s = 1'b0; wb_stb_s = 1'b0;
      step();
      check("b2b_ack_end", 32'(wb_ack_s), 32'd0);

      // W1C in the same cycle as a new edge
      wr(32'h00, 32'h00);
      irq_src[3] = 1'b1;
      step();
      wr(32'h04, 32'hFF);
      rd_chk("w1c_vs_set", 32'h04, 32'h08);
      irq_src[3] = 1'b0;
      wr(32'h04, 32'h08);
      rd_chk("w1c_cleanup", 32'h04, 32'h0);

      // Reset in ACTIVE with a read in flight
      wr(32'h40, 32'h1234);
      wr(32'h00, 32'h01);
      irq_src[0] = 1'b1;
      wait_irq(8'h01, cnt);
      pulse_ack();
      wb_cyc_s = 1'b1; wb_stb_s = 1'b1; wb_we_s = 1'b0; wb_adr_s = 32'h08;
      @(posedge clk);
      #1;
      check("pre_rst_ack", 32'(wb_ack_s), 32'd1);
      wb_cyc_s = 1'b0; wb_stb_s = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("arst_ack", 32'(wb_ack_s),    32'd0);
      check("arst_dat", wb_dat_o_s,       32'd0);
      check("arst_irq", 32'(cpu_irq),     32'd0);
      check("arst_adr", 32'(interuptadr), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      rd_chk("post_rst_status", 32'h08, 32'h0);
      rd_chk("post_rst_enable", 32'h00, 32'h0);
      rd_chk("post_rst_vec0",   32'h40, 32'h0);
      rd_chk("post_rst_pend",   32'h04, 32'h0);

      // Randomized pipelined traffic against the register-file model
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      for (int k = 0; k < 300; k++) begin
         int          kind;
         int          idx;
         int          u;
         bit          act;
         bit          we;
         logic [31:0] dat;
         logic [31:0] up;
         logic [3:0]  sel;
         logic [31:0] exp;
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: idx = 0;
            1: idx = 16 + int'($urandom_range(0, NUM - 1));
            2: idx = 1;
            default: begin
               u = int'($urandom_range(0, 20));
               idx = (u < 13) ? 3 + u : 24 + (u - 13);
            end
         endcase
         act = ($urandom_range(0, 9) != 0);
         we  = 1'($urandom_range(0, 1));
         dat = $urandom;
         up  = $urandom;
         sel = 4'($urandom_range(0, 15));
         if (act) begin
            wb_cyc_s = 1'b1; wb_stb_s = 1'b1;
         end else begin
            wb_cyc_s = 1'($urandom_range(0, 1));
            wb_stb_s = ~wb_cyc_s;
         end
         wb_we_s = we; wb_adr_s = {up[31:7], 5'(idx), 2'b00};
         wb_dat_i_s = dat; wb_sel_s = sel;
         exp = (act && !we) ? model[idx] : 32'd0;
         step();
         checks++;
         if (wb_ack_s !== act || wb_dat_o_s !== exp) begin
            errors++;
            $display("FAIL rnd%0d ack=%b act=%h exp_ack=%b exp=%h",
                     k, wb_ack_s, wb_dat_o_s, act, exp);
         end
         $display("txn rnd%0d act=%0b we=%0b idx=%0d sel=%h rd=%h", k, act, we, idx, sel, wb_dat_o_s);
         if (act && we) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) model[idx][8*b +: 8] = dat[8*b +: 8];
            model[idx] = model[idx] & hold_mask(idx);
         end
      end
      wb_cyc_s = 1'b0; wb_stb_s = 1'b0; wb_we_s = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
